// File: rtl/baud_gen_pkg.sv
// ---------------------------------------------------------------------------
// baud_gen_pkg
// Shared types and helpers for the multi-channel baud tick generator.
//   baud_cfg_t : {div_int, div_frac} divisor pair (32-bit fields, sliced by
//                users to their DIV_W / FRAC_W).
//   baud_div() : truncated divisor for a clock/baud/oversample combination.
//   OS_MIN/OS_MAX/MIN_DIV : legal OVERSAMPLE range and smallest divisor.
// Optional feature macro used by the users of this package: BAUD_GEN_FRAC_EN.
// ---------------------------------------------------------------------------
package baud_gen_pkg;

  localparam int OS_MIN  = 4;
  localparam int OS_MAX  = 32;
  localparam int MIN_DIV = 2;

  typedef struct packed {
    logic [31:0] div_int;
    logic [31:0] div_frac;
  } baud_cfg_t;

  // D = freq / (baud * os), integer part plus frac_w fractional bits, truncated.
  function automatic baud_cfg_t baud_div(input longint unsigned freq,
                                         input longint unsigned baud,
                                         input longint unsigned os,
                                         input int frac_w = 8);
    longint unsigned den;
    longint unsigned rem;
    baud_cfg_t       res;
    den          = baud * os;
    res.div_int  = 32'(freq / den);
    rem          = freq % den;
    res.div_frac = 32'((rem << frac_w) / den);
    return res;
  endfunction

endpackage

// File: rtl/baud_gen_ch.sv
// ---------------------------------------------------------------------------
// baud_gen_ch
// One baud channel: down-counter with fractional carry, oversample counter,
// registered tick/bit-clock outputs and a shadow divisor with pending flag.
// Ports:
//   clk, rst_n       : system clock, async active-low reset
//   ch_en            : run enable; low holds counter/acc/os_cnt/outputs at 0
//   wr, wr_int       : shadow write strobe and integer divisor (from top)
//   wr_frac          : fractional divisor (only with BAUD_GEN_FRAC_EN)
//   pending          : shadow written but not yet applied
//   tick_os          : one-cycle oversample tick
//   tick_bit         : one-cycle tick on the os_cnt wrap
//   bit_clk          : high while os_cnt >= OVERSAMPLE/2
// Macro: BAUD_GEN_FRAC_EN adds the fractional accumulator.
// ---------------------------------------------------------------------------
module baud_gen_ch
  import baud_gen_pkg::*;
#(
  parameter int                DIV_W      = 16,
`ifdef BAUD_GEN_FRAC_EN
  parameter int                FRAC_W     = 8,
  parameter logic [FRAC_W-1:0] RST_FRAC   = '0,
`endif
  parameter int                OVERSAMPLE = 16,
  parameter logic [DIV_W-1:0]  RST_INT    = DIV_W'(651)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ch_en,
  input  logic              wr,
  input  logic [DIV_W-1:0]  wr_int,
`ifdef BAUD_GEN_FRAC_EN
  input  logic [FRAC_W-1:0] wr_frac,
`endif
  output logic              pending,
  output logic              tick_os,
  output logic              tick_bit,
  output logic              bit_clk
);

  localparam int              OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2);

  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  div_int;
  logic [DIV_W-1:0]  shadow_int;
  logic [DIV_W-1:0]  reload_int;
  logic [DIV_W-1:0]  reload;
  logic [OS_W-1:0]   os_cnt;
  logic [OS_W-1:0]   os_nxt;
  logic              en_d;
  logic              tick;
  logic              apply;
  logic              carry;
`ifdef BAUD_GEN_FRAC_EN
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W-1:0] acc_nxt;
  logic [FRAC_W-1:0] div_frac;
  logic [FRAC_W-1:0] shadow_frac;
`endif

  // Tick detect, shadow-apply decision, reload value and next os_cnt.
  always_comb begin
    tick       = en_d & ch_en & (cnt == '0);
    // en_d low covers both "disabled for a full cycle" and "just re-enabled":
    // a pending shadow is taken there without waiting for a tick.
    apply      = pending & (~en_d | tick);
    reload_int = apply ? shadow_int : div_int;
`ifdef BAUD_GEN_FRAC_EN
    {carry, acc_nxt} = {1'b0, acc} + {1'b0, div_frac};
`else
    carry      = 1'b0;
`endif
    // A freshly applied divisor starts with acc cleared, so no carry then.
    reload     = reload_int - DIV_W'(1) + DIV_W'(carry & ~apply);
    if (tick) begin
      os_nxt = (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
    end else begin
      os_nxt = os_cnt;
    end
  end

  // Counter, accumulator, oversample counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      os_cnt   <= '0;
      en_d     <= 1'b0;
      tick_os  <= 1'b0;
      tick_bit <= 1'b0;
      bit_clk  <= 1'b0;
`ifdef BAUD_GEN_FRAC_EN
      acc      <= '0;
`endif
    end else if (!ch_en) begin
      cnt      <= '0;
      os_cnt   <= '0;
      en_d     <= 1'b0;
      tick_os  <= 1'b0;
      tick_bit <= 1'b0;
      bit_clk  <= 1'b0;
`ifdef BAUD_GEN_FRAC_EN
      acc      <= '0;
`endif
    end else begin
      en_d <= 1'b1;
      if (!en_d) begin
        // First enabled cycle: first tick lands div_int cycles from here.
        cnt <= reload_int - DIV_W'(1);
`ifdef BAUD_GEN_FRAC_EN
        acc <= '0;
`endif
      end else if (tick) begin
        cnt <= reload;
`ifdef BAUD_GEN_FRAC_EN
        acc <= apply ? '0 : acc_nxt;
`endif
      end else begin
        cnt <= cnt - DIV_W'(1);
      end
      os_cnt   <= os_nxt;
      tick_os  <= tick;
      tick_bit <= tick & (os_cnt == OS_LAST);
      bit_clk  <= (os_nxt >= OS_HALF);
    end
  end

  // Active/shadow divisor registers and pending flag; retained while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_int     <= RST_INT;
      shadow_int  <= RST_INT;
      pending     <= 1'b0;
`ifdef BAUD_GEN_FRAC_EN
      div_frac    <= RST_FRAC;
      shadow_frac <= RST_FRAC;
`endif
    end else if (wr) begin
      // The top only writes when pending is low, so wr and apply never meet.
      shadow_int  <= wr_int;
      pending     <= 1'b1;
`ifdef BAUD_GEN_FRAC_EN
      shadow_frac <= wr_frac;
`endif
    end else if (apply) begin
      div_int     <= shadow_int;
      pending     <= 1'b0;
`ifdef BAUD_GEN_FRAC_EN
      div_frac    <= shadow_frac;
`endif
    end
  end

endmodule

// File: rtl/baud_gen_multi.sv
// ---------------------------------------------------------------------------
// baud_gen_multi
// Multi-channel programmable baud tick generator. Each channel produces an
// oversample tick, a bit tick and a 50% bit clock from clk, with an integer
// (optionally fractional) divisor loaded through a valid/ready config port.
// Ports:
//   clk, rst_n    : system clock, async active-low reset
//   ch_en         : per-channel run enable
//   cfg_valid     : config request
//   cfg_ready     : request accepted when high with cfg_valid (combinational
//                   from cfg_ch: low while that channel has a pending shadow)
//   cfg_ch        : target channel
//   cfg_div_int   : clk cycles per oversample tick, integer part (>= 2)
//   cfg_div_frac  : fractional part in 2^-FRAC_W units
//   cfg_err       : one-cycle pulse when a consumed request is rejected
//   tick_os, tick_bit, bit_clk : per-channel registered outputs
// Macro: BAUD_GEN_FRAC_EN enables the fractional accumulator; without it
// cfg_div_frac is ignored and every period is exactly div_int.
// ---------------------------------------------------------------------------
module baud_gen_multi
  import baud_gen_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 100_000_000,
  parameter int NUM_CH       = 4,
  parameter int DIV_W        = 16,
  parameter int FRAC_W       = 8,
  parameter int OVERSAMPLE   = 16,
  parameter int RST_BAUD     = 9600
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_CH-1:0]                         ch_en,
  input  logic                                      cfg_valid,
  output logic                                      cfg_ready,
  input  logic [$clog2(NUM_CH > 1 ? NUM_CH : 2)-1:0] cfg_ch,
  input  logic [DIV_W-1:0]                          cfg_div_int,
  input  logic [FRAC_W-1:0]                         cfg_div_frac,
  output logic                                      cfg_err,
  output logic [NUM_CH-1:0]                         tick_os,
  output logic [NUM_CH-1:0]                         tick_bit,
  output logic [NUM_CH-1:0]                         bit_clk
);

  localparam int        CH_W    = $clog2(NUM_CH > 1 ? NUM_CH : 2);
  localparam baud_cfg_t RST_CFG = baud_div(64'(SYS_CLK_FREQ), 64'(RST_BAUD),
                                           64'(OVERSAMPLE), FRAC_W);
  localparam logic [DIV_W-1:0] RST_INT = RST_CFG.div_int[DIV_W-1:0];

  if (OVERSAMPLE < OS_MIN || OVERSAMPLE > OS_MAX || (OVERSAMPLE % 2) != 0 ||
      NUM_CH < 1 || NUM_CH > 16) begin : g_bad_param
    $error("baud_gen_multi: OVERSAMPLE must be even in 4..32 and NUM_CH in 1..16");
  end

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] wr;
  logic              ch_ok;
  logic              div_ok;
  logic              accept;
  logic              reject;

  // Channel index range check is only needed when NUM_CH is not a power of two.
  if ((1 << CH_W) == NUM_CH) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    assign ch_ok = (int'(cfg_ch) < NUM_CH);
  end

  // Config decode: ready mux, divisor legality, write strobe and reject.
  always_comb begin
    if (ch_ok) begin
      cfg_ready = ~pending[cfg_ch];
    end else begin
      cfg_ready = 1'b1;
    end
    accept = cfg_valid & cfg_ready;
    div_ok = (cfg_div_int >= DIV_W'(MIN_DIV));
    wr     = '0;
    if (accept && ch_ok && div_ok) begin
      wr[cfg_ch] = 1'b1;
    end else begin
      wr = '0;
    end
    reject = accept & ~(ch_ok & div_ok);
  end

  // Rejected requests are consumed and flagged for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= reject;
    end
  end

`ifndef BAUD_GEN_FRAC_EN
  logic unused_frac;
  assign unused_frac = ^cfg_div_frac;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    baud_gen_ch #(
      .DIV_W      (DIV_W),
`ifdef BAUD_GEN_FRAC_EN
      .FRAC_W     (FRAC_W),
      .RST_FRAC   (RST_CFG.div_frac[FRAC_W-1:0]),
`endif
      .OVERSAMPLE (OVERSAMPLE),
      .RST_INT    (RST_INT)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .ch_en    (ch_en[i]),
      .wr       (wr[i]),
      .wr_int   (cfg_div_int),
`ifdef BAUD_GEN_FRAC_EN
      .wr_frac  (cfg_div_frac),
`endif
      .pending  (pending[i]),
      .tick_os  (tick_os[i]),
      .tick_bit (tick_bit[i]),
      .bit_clk  (bit_clk[i])
    );
  end

endmodule

// File: tb/tb_baud_gen_multi.sv
// ---------------------------------------------------------------------------
// tb_baud_gen_multi
// Self-checking bench for baud_gen_multi with default parameters. Expected
// tick gaps come from a small accumulator model; with BAUD_GEN_FRAC_EN
// undefined the model drops the fractional part.
// ---------------------------------------------------------------------------
module tb_baud_gen_multi;

`ifdef BAUD_GEN_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ch_en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div_int;
  logic [7:0]  cfg_div_frac;
  logic        cfg_err;
  logic [3:0]  tick_os;
  logic [3:0]  tick_bit;
  logic [3:0]  bit_clk;

  int checks = 0;
  int errors = 0;

  baud_gen_multi dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ch_en        (ch_en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_ch       (cfg_ch),
    .cfg_div_int  (cfg_div_int),
    .cfg_div_frac (cfg_div_frac),
    .cfg_err      (cfg_err),
    .tick_os      (tick_os),
    .tick_bit     (tick_bit),
    .bit_clk      (bit_clk)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int cfg_int;
    int cfg_frac;
    int exp_err;
    int exp_int;
    int exp_frac;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Waits for tick_os[ch]; cyc = negedges elapsed, -1 on timeout.
  task automatic wait_tick(input int ch, input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (tick_os[ch] == 1'b0 && cyc < limit);
    if (tick_os[ch] == 1'b0) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: ch%0d no tick_os within %0d cycles", ch, limit);
      cyc = -1;
    end
  endtask

  task automatic do_cfg(input int ch, input int di, input int df);
    cfg_ch       = 2'(ch);
    cfg_div_int  = 16'(di);
    cfg_div_frac = 8'(df);
    cfg_valid    = 1'b1;
    @(negedge clk);
    cfg_valid    = 1'b0;
  endtask

  // Gap following a tick: D plus the carry of acc + frac.
  function automatic int model_gap(input int d, input int f, inout int acc);
    int s;
    s   = acc + (FRAC_ON ? f : 0);
    acc = s & 255;
    return d + (s >> 8);
  endfunction

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, acc, exp, hi, lo, n;
    bit stuck;

    vecs[0] = '{1, 4,   'h80, 0, 4,   'h80};
    vecs[1] = '{3, 2,   'h00, 0, 2,   'h00};
    vecs[2] = '{2, 1,   'h33, 1, 651, 10};
    vecs[3] = '{0, 0,   'h00, 1, 651, 10};
    vecs[4] = '{2, 7,   'h40, 0, 7,   'h40};
    vecs[5] = '{3, 3,   'hFF, 0, 3,   'hFF};

    rst_n = 1'b0; ch_en = '0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_div_int = '0; cfg_div_frac = '0;
    repeat (3) @(negedge clk);
    check("rst_tick_os",  int'(tick_os),  0);
    check("rst_tick_bit", int'(tick_bit), 0);
    check("rst_bit_clk",  int'(bit_clk),  0);
    check("rst_cfg_err",  int'(cfg_err),  0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      cfg_ch = 2'(c);
      #1;
      check("rst_cfg_ready", int'(cfg_ready), 1);
    end
    @(negedge clk);

    // Table: config a disabled channel, then run it and compare tick gaps.
    for (int i = 0; i < 6; i++) begin
      cfg_ch = 2'(vecs[i].ch);
      #1;
      check("tbl_ready_idle", int'(cfg_ready), 1);
      do_cfg(vecs[i].ch, vecs[i].cfg_int, vecs[i].cfg_frac);
      check("tbl_cfg_err", int'(cfg_err), vecs[i].exp_err);
      check("tbl_ready_pending", int'(cfg_ready), vecs[i].exp_err);
      @(negedge clk);
      check("tbl_err_pulse", int'(cfg_err), 0);
      check("tbl_ready_applied", int'(cfg_ready), 1);
      ch_en[vecs[i].ch] = 1'b1;
      wait_tick(vecs[i].ch, 2000, cyc);
      check("tbl_first_tick", cyc - 1, vecs[i].exp_int);
      acc = 0;
      for (int k = 0; k < 4; k++) begin
        wait_tick(vecs[i].ch, 2000, cyc);
        exp = model_gap(vecs[i].exp_int, vecs[i].exp_frac, acc);
        check("tbl_gap", cyc, exp);
      end
      ch_en[vecs[i].ch] = 1'b0;
      @(negedge clk);
    end

    // Reset divisor on channel 0: 651/652 gaps, tick_bit every 16th tick.
    ch_en[0] = 1'b1;
    wait_tick(0, 2000, cyc);
    check("ch0_first_tick", cyc - 1, 651);
    check("ch0_tick_bit_1", int'(tick_bit[0]), 0);
    acc = 0;
    for (int k = 2; k <= 48; k++) begin
      wait_tick(0, 2000, cyc);
      exp = model_gap(651, 10, acc);
      check("ch0_gap", cyc, exp);
      check("ch0_tick_bit", int'(tick_bit[0]), int'(k % 16 == 0));
    end
    ch_en[0] = 1'b0;
    @(negedge clk);

    // bit_clk on channel 1 (div 4 + 0x80/256): 72-cycle period, 36 high.
    ch_en[1] = 1'b1;
    n = 0;
    while (!bit_clk[1] && n < 2000) begin @(negedge clk); n++; end
    hi = 0;
    while (bit_clk[1] && hi < 2000) begin @(negedge clk); hi++; end
    lo = 0;
    while (!bit_clk[1] && lo < 2000) begin @(negedge clk); lo++; end
    check("bitclk_high", hi, FRAC_ON ? 36 : 32);
    check("bitclk_period", hi + lo, FRAC_ON ? 72 : 64);
    ch_en[1] = 1'b0;
    @(negedge clk);

    // Live reconfiguration of running channel 2 (100 -> 50).
    do_cfg(2, 100, 0);
    check("live_cfg_err", int'(cfg_err), 0);
    @(negedge clk);
    ch_en[2] = 1'b1;
    wait_tick(2, 2000, cyc);
    check("live_first_tick", cyc - 1, 100);
    repeat (30) @(negedge clk);
    do_cfg(2, 50, 0);
    check("live_ready_low", int'(cfg_ready), 0);
    cfg_ch = 2'(3);
    #1;
    check("live_ready_other", int'(cfg_ready), 1);
    cfg_ch = 2'(2);
    #1;
    check("live_ready_low2", int'(cfg_ready), 0);
    wait_tick(2, 2000, cyc);
    check("live_old_gap", cyc + 31, 100);
    check("live_ready_back", int'(cfg_ready), 1);
    check("live_tick_bit_2", int'(tick_bit[2]), 0);
    for (int k = 3; k <= 25; k++) begin
      wait_tick(2, 2000, cyc);
      check("live_new_gap", cyc, 50);
      check("live_tick_bit", int'(tick_bit[2]), int'(k == 16));
    end
    check("live_bitclk_high", int'(bit_clk[2]), 1);

    // Disable mid-period, hold 10 cycles, re-enable.
    repeat (20) @(negedge clk);
    ch_en[2] = 1'b0;
    @(negedge clk);
    check("dis_outputs", int'({tick_os[2], tick_bit[2], bit_clk[2]}), 0);
    stuck = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (tick_os[2] | tick_bit[2] | bit_clk[2]) stuck = 1'b1;
    end
    check("dis_quiet", int'(stuck), 0);
    ch_en[2] = 1'b1;
    wait_tick(2, 2000, cyc);
    check("reen_first_tick", cyc - 1, 50);

    // Asynchronous reset mid-operation.
    ch_en[1] = 1'b1;
    n = 0;
    while (!bit_clk[1] && n < 2000) begin @(negedge clk); n++; end
    check("prerst_bitclk", int'(bit_clk[1]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tick_os",  int'(tick_os),  0);
    check("arst_tick_bit", int'(tick_bit), 0);
    check("arst_bit_clk",  int'(bit_clk),  0);
    check("arst_cfg_err",  int'(cfg_err),  0);
    ch_en = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cfg_ch = 2'(1);
    #1;
    check("postrst_ready", int'(cfg_ready), 1);
    ch_en[1] = 1'b1;
    wait_tick(1, 2000, cyc);
    check("postrst_first_tick", cyc - 1, 651);
    wait_tick(1, 2000, cyc);
    check("postrst_gap", cyc, 651);
    ch_en = '0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
